cpu_cycle_sequencer: RTL
========================

# cpu_cycle_sequencer

Multi-cycle sequencer for the femtoRV32 core's single-ported unified instruction/data memory. It steps each instruction through fetch, execute, optional memory access and write-back. It gates the PC, instruction register, memory data register and register-file write enables, and runs the variable-latency memory handshake. It sits between the main control decoder (which supplies MemRead/MemWrite/RegWrite from the latched instruction) and the datapath enables.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum wait cycles with mem_ready low before a bus error; 0 disables the timeout.
- CNT_W, default 32: width of the instret counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- mem_ready  in  1  memory completes the current access this cycle (read data valid same cycle)
- MemRead  in  1  decoded load, from main control
- MemWrite  in  1  decoded store, from main control
- RegWrite  in  1  decoded register write, from main control
- halt_req  in  1  decoded EBREAK/ECALL, from main control
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualified by mem_req
- addr_sel  out  1  memory address mux: 0 = PC, 1 = ALU result
- ir_en  out  1  load instruction register
- mdr_en  out  1  load memory data register
- pc_en  out  1  load next PC
- rf_we  out  1  register-file write enable
- halted  out  1  core stopped
- bus_err  out  1  stop was caused by a memory timeout
- state  out  3  current state, for debug
- instret  out  CNT_W  retired-instruction count

## Operation
- States: BOOT, FETCH, EXEC, MEM, WB, HALT.
- All outputs decode combinationally from the state register, mem_ready and the decode inputs. Only state, the wait counter, bus_err and instret are registered.
- **BOOT** (reset value): all outputs 0. Unconditionally goes to FETCH.
- **FETCH**: mem_req=1, addr_sel=0, mem_we=0; ir_en = mem_ready.
  - mem_ready=1 → EXEC; otherwise stay.
- **EXEC**: no outputs asserted; the ALU settles.
  - MemRead|MemWrite → MEM; else → WB.
- **MEM**: mem_req=1, addr_sel=1, mem_we=MemWrite; mdr_en = mem_ready & ~MemWrite.
  - MemRead and MemWrite both 1 is treated as a store.
  - mem_ready=1 → WB; otherwise stay.
- **WB**: rf_we=RegWrite; pc_en = ~halt_req; instret increments.
  - halt_req → HALT; else → FETCH.
- **HALT**: halted=1; all other enables 0. Only reset leaves HALT. bus_err holds its value.
- Wait counter:
  - Clears on every entry to FETCH or MEM.
  - Increments each FETCH/MEM cycle in which mem_ready=0.
  - If the count equals TIMEOUT_CYCLES-1 and mem_ready=0: next state is HALT and bus_err is set to 1.
- mem_ready is ignored whenever mem_req=0.
- instret wraps from all-ones to 0.

## Timing
- Reset values: state=BOOT, instret=0, bus_err=0, wait counter=0. All outputs are 0 during and on the first cycle after reset.
- rst_n is sampled only on the clock edge. Reset mid-access drops mem_req on the next cycle with no completion.
- Instruction latency with zero-wait memory (mem_ready high in the first request cycle):
  - ALU/branch/jump: 3 cycles (FETCH, EXEC, WB).
  - Load/store: 4 cycles (FETCH, EXEC, MEM, WB).
- Each wait cycle adds one cycle.
- The first fetch request occurs on the 2nd cycle after rst_n rises.
- Handshake rules:
  - mem_req, addr_sel and mem_we stay stable from assertion until the cycle mem_ready=1.
  - Exactly one completion is taken per request.
- Timeout: at most TIMEOUT_CYCLES consecutive waiting cycles; HALT follows the next cycle.
- mem_ready=1 in the same cycle the counter reaches its limit: the access completes and there is no error.

## Structure
- State encodings go in defines.v as SEQ_BOOT=0, SEQ_FETCH=1, SEQ_EXEC=2, SEQ_MEM=3, SEQ_WB=4, SEQ_HALT=5.
- Sub-module mem_wait_timer: the clear/increment/limit counter, parameterized by TIMEOUT_CYCLES, with a single expired output.

## Test plan
- Reset, then ADD decode (RegWrite=1, others 0) with mem_ready tied 1 → states BOOT, FETCH, EXEC, WB, FETCH; ir_en in cycle 2, rf_we and pc_en in cycle 4; instret=1.
- LW (MemRead=1, RegWrite=1) with mem_ready low for 2 cycles in MEM → MEM lasts 3 cycles; addr_sel=1, mem_we=0 throughout; mdr_en only in the ready cycle; 6 cycles total.
- SW (MemWrite=1) with zero wait → mem_we=1 only in MEM; rf_we=0 in WB; instret increments.
- TIMEOUT_CYCLES=4 with mem_ready held 0 in FETCH → 4 FETCH cycles, then HALT with bus_err=1 and halted=1; stays in HALT until rst_n=0, then returns to BOOT with bus_err=0.
- halt_req=1 with RegWrite=1 → WB asserts rf_we=1 and pc_en=0; instret increments; HALT with bus_err=0.
- instret preloaded near 0xFFFFFFFF (force) then 2 retirements → wraps to 0x00000001.

Source files
------------

// File: rtl/cpu_cycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer.
//   seq_state_t     : sequencer state encoding, also driven on the debug state port
//   wait_cnt_width  : bit width of the memory wait counter for a given timeout
package cpu_cycle_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_BOOT  = 3'd0,
        SEQ_FETCH = 3'd1,
        SEQ_EXEC  = 3'd2,
        SEQ_MEM   = 3'd3,
        SEQ_WB    = 3'd4,
        SEQ_HALT  = 3'd5
    } seq_state_t;

    // The counter only has to reach timeout-1, so clog2(timeout) bits suffice.
    function automatic int unsigned wait_cnt_width(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/cpu_cycle_sequencer_mem_wait_timer.sv
// Memory wait timer: counts consecutive cycles of an outstanding access with
// no ready response and flags expiry on the last allowed waiting cycle.
// Ports:
//   clk     in   core clock
//   rst_n   in   synchronous active-low reset
//   active  in   an access is outstanding this cycle (FETCH or MEM)
//   ready   in   memory completes the access this cycle
//   expired out  this waiting cycle is the last one allowed; abort the access
module cpu_cycle_sequencer_mem_wait_timer
    import cpu_cycle_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam int unsigned W       = wait_cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned LIMIT_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [W-1:0] LIMIT  = W'(LIMIT_I);

    logic [W-1:0] count;

    // Held at zero outside an access, so every entry to FETCH/MEM starts at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active || expired) begin
            count <= '0;
        end else if (!ready) begin
            count <= count + W'(1);
        end
    end

    // A ready in the limit cycle wins: the access completes without error.
    assign expired = (TIMEOUT_CYCLES != 0) && active && !ready && (count == LIMIT);

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Multi-cycle sequencer for a core with a single-ported unified memory.
// Steps each instruction through fetch, execute, optional memory access and
// write-back, gating the datapath enables and running the memory handshake.
// Ports:
//   clk        in   core clock
//   rst_n      in   synchronous active-low reset
//   mem_ready  in   memory completes the current access this cycle
//   MemRead    in   decoded load
//   MemWrite   in   decoded store (wins when MemRead is also set)
//   RegWrite   in   decoded register write
//   halt_req   in   decoded EBREAK/ECALL
//   mem_req    out  memory access request
//   mem_we     out  write strobe, qualified by mem_req
//   addr_sel   out  memory address mux: 0 = PC, 1 = ALU result
//   ir_en      out  load instruction register
//   mdr_en     out  load memory data register
//   pc_en      out  load next PC
//   rf_we      out  register-file write enable
//   halted     out  core stopped
//   bus_err    out  stop was caused by a memory timeout
//   state      out  current state (debug)
//   instret    out  retired-instruction count
//
// state | meaning
// BOOT  | reset state, all outputs low, moves to FETCH
// FETCH | instruction read at PC, wait for mem_ready
// EXEC  | ALU settles, choose MEM or WB
// MEM   | load/store at ALU address, wait for mem_ready
// WB    | register write, PC update, retire
// HALT  | stopped until reset
module cpu_cycle_sequencer
    import cpu_cycle_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_ready,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             RegWrite,
    input  logic             halt_req,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_en,
    output logic             mdr_en,
    output logic             pc_en,
    output logic             rf_we,
    output logic             halted,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    seq_state_t state_q;
    seq_state_t state_nxt;
    logic       wait_active;
    logic       wait_expired;
    logic       set_err;
    logic       retire;

    assign wait_active = (state_q == SEQ_FETCH) || (state_q == SEQ_MEM);

    cpu_cycle_sequencer_mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (wait_active),
        .ready   (mem_ready),
        .expired (wait_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEQ_BOOT;
            bus_err <= 1'b0;
            instret <= '0;
        end else begin
            state_q <= state_nxt;
            if (set_err) begin
                bus_err <= 1'b1;
            end
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_en     = 1'b0;
        mdr_en    = 1'b0;
        pc_en     = 1'b0;
        rf_we     = 1'b0;
        halted    = 1'b0;
        set_err   = 1'b0;
        retire    = 1'b0;

        case (state_q)
            SEQ_BOOT: begin
                state_nxt = SEQ_FETCH;
            end
            SEQ_FETCH: begin
                mem_req = 1'b1;
                ir_en   = mem_ready;
                if (mem_ready) begin
                    state_nxt = SEQ_EXEC;
                end else if (wait_expired) begin
                    state_nxt = SEQ_HALT;
                    set_err   = 1'b1;
                end
            end
            SEQ_EXEC: begin
                state_nxt = (MemRead || MemWrite) ? SEQ_MEM : SEQ_WB;
            end
            SEQ_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = MemWrite;
                mdr_en   = mem_ready && !MemWrite;
                if (mem_ready) begin
                    state_nxt = SEQ_WB;
                end else if (wait_expired) begin
                    state_nxt = SEQ_HALT;
                    set_err   = 1'b1;
                end
            end
            SEQ_WB: begin
                rf_we     = RegWrite;
                pc_en     = !halt_req;
                retire    = 1'b1;
                state_nxt = halt_req ? SEQ_HALT : SEQ_FETCH;
            end
            SEQ_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = SEQ_BOOT;
            end
        endcase
    end

    assign state = state_q;

endmodule
